// File: rtl/resource_fsm_receiver.sv
// ============================================================================
// Module   : resource_fsm_receiver
// Brief    : Slot instruction receiver driving FSM_PER_SLOT independent
//            address generators (IDLE/RUN/GAP). Optional sticky err output
//            is enabled by defining RESOURCE_FSM_RECEIVER_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module resource_fsm_receiver #(
   parameter int FSM_PER_SLOT         = 4,
   parameter int RESOURCE_INSTR_WIDTH = 27,
   parameter int ADDR_WIDTH           = 6
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               instr_valid,
   input  logic [RESOURCE_INSTR_WIDTH-1:0]    instr,
   input  logic [FSM_PER_SLOT-1:0]            activate,
   output logic [FSM_PER_SLOT-1:0]            addr_valid,
   output logic [FSM_PER_SLOT*ADDR_WIDTH-1:0] addr,
   output logic [FSM_PER_SLOT-1:0]            busy
`ifdef RESOURCE_FSM_RECEIVER_ERR_EN
   ,
   output logic                               err
`endif
);

   localparam logic [2:0] c_OP_DSU = 3'd1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   logic w_dsu;
   assign w_dsu = instr_valid && (instr[26:24] == c_OP_DSU);

   for (genvar p = 0; p < FSM_PER_SLOT; p++) begin : g_port
      state_t                r_state, w_state_nxt;
      logic [5:0]            r_cfg_init, r_cfg_iter, r_cfg_delay;
      logic [3:0]            r_cfg_step;
      logic [ADDR_WIDTH-1:0] r_cur, w_cur_nxt;
      logic [3:0]            r_step;
      logic [5:0]            r_delay;
      logic [5:0]            r_remain, w_remain_nxt;
      logic [5:0]            r_gap, w_gap_nxt;
      logic                  r_valid, w_valid_nxt;
      logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
      logic                  r_busy;
      logic                  w_load;
      logic                  w_cfg_wr;

      assign w_cfg_wr = w_dsu && (instr[23:22] == 2'(p));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cfg_init  <= '0;
            r_cfg_step  <= '0;
            r_cfg_iter  <= '0;
            r_cfg_delay <= '0;
            r_cur       <= '0;
            r_step      <= '0;
            r_delay     <= '0;
            r_remain    <= '0;
            r_gap       <= '0;
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_busy      <= 1'b0;
         end else begin
            r_state  <= w_state_nxt;
            r_cur    <= w_cur_nxt;
            r_remain <= w_remain_nxt;
            r_gap    <= w_gap_nxt;
            r_valid  <= w_valid_nxt;
            r_addr   <= w_addr_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            // Working copy is taken from the config held before this edge.
            if (w_load) begin
               r_step  <= r_cfg_step;
               r_delay <= r_cfg_delay;
            end
            if (w_cfg_wr) begin
               r_cfg_init  <= instr[21:16];
               r_cfg_step  <= instr[15:12];
               r_cfg_iter  <= instr[11:6];
               r_cfg_delay <= instr[5:0];
            end
         end
      end

      always_comb begin
         w_state_nxt  = r_state;
         w_cur_nxt    = r_cur;
         w_remain_nxt = r_remain;
         w_gap_nxt    = r_gap;
         w_valid_nxt  = 1'b0;
         w_addr_nxt   = '0;
         w_load       = 1'b0;
         case (r_state)
            S_IDLE: begin
               if (activate[p]) begin
                  w_load       = 1'b1;
                  w_state_nxt  = S_RUN;
                  w_cur_nxt    = ADDR_WIDTH'(r_cfg_init);
                  w_remain_nxt = r_cfg_iter;
                  w_valid_nxt  = 1'b1;
                  w_addr_nxt   = ADDR_WIDTH'(r_cfg_init);
               end
            end
            S_RUN: begin
               if (r_remain == 6'd0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cur_nxt    = r_cur + ADDR_WIDTH'(r_step);
                  w_remain_nxt = r_remain - 6'd1;
                  if (r_delay == 6'd0) begin
                     w_valid_nxt = 1'b1;
                     w_addr_nxt  = w_cur_nxt;
                  end else begin
                     w_state_nxt = S_GAP;
                     w_gap_nxt   = r_delay;
                  end
               end
            end
            S_GAP: begin
               if (r_gap == 6'd1) begin
                  w_state_nxt = S_RUN;
                  w_valid_nxt = 1'b1;
                  w_addr_nxt  = r_cur;
               end else begin
                  w_gap_nxt = r_gap - 6'd1;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end

      assign addr_valid[p]                     = r_valid;
      assign addr[p*ADDR_WIDTH +: ADDR_WIDTH]  = r_addr;
      assign busy[p]                           = r_busy;
   end

`ifdef RESOURCE_FSM_RECEIVER_ERR_EN
   logic r_err;
   // busy mirrors the port state, so activate&busy flags a restart attempt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if ((|(activate & busy)) || (instr_valid && (instr[26:24] != c_OP_DSU))) begin
         r_err <= 1'b1;
      end
   end
   assign err = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_resource_fsm_receiver.sv
// ============================================================================
// Module   : tb_resource_fsm_receiver
// Brief    : Self-checking bench for resource_fsm_receiver (schedule model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_resource_fsm_receiver;
   localparam int F = 4;
   localparam int W = 27;
   localparam int A = 6;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           instr_valid = 1'b0;
   logic [W-1:0]   instr = '0;
   logic [F-1:0]   activate = '0;
   wire  [F-1:0]   addr_valid;
   wire  [F*A-1:0] addr;
   wire  [F-1:0]   busy;
`ifdef RESOURCE_FSM_RECEIVER_ERR_EN
   wire            err;
`endif

   resource_fsm_receiver #(
      .FSM_PER_SLOT(F), .RESOURCE_INSTR_WIDTH(W), .ADDR_WIDTH(A)
   ) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
      .activate(activate), .addr_valid(addr_valid), .addr(addr), .busy(busy)
`ifdef RESOURCE_FSM_RECEIVER_ERR_EN
      , .err(err)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a run started at edge s emits init+k*step on edge s+k*(delay+1), k=0..iter.
   int m_init[F], m_step[F], m_iter[F], m_delay[F];
   int r_init[F], r_step[F], r_iter[F], r_delay[F], r_start[F];
   bit r_act[F];
   bit m_err;
   int edge_no;

   function automatic bit m_busy(input int p, input int e);
      int o = e - r_start[p];
      return r_act[p] && (o >= 0) && (o <= r_iter[p] * (r_delay[p] + 1));
   endfunction

   function automatic bit m_valid(input int p, input int e);
      return m_busy(p, e) && (((e - r_start[p]) % (r_delay[p] + 1)) == 0);
   endfunction

   function automatic int m_addr(input int p, input int e);
      if (!m_valid(p, e)) return 0;
      return (r_init[p] + ((e - r_start[p]) / (r_delay[p] + 1)) * r_step[p]) % (1 << A);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_no <= 0;
         m_err   <= 1'b0;
         for (int p = 0; p < F; p++) begin
            m_init[p] <= 0; m_step[p] <= 0; m_iter[p] <= 0; m_delay[p] <= 0;
            r_init[p] <= 0; r_step[p] <= 0; r_iter[p] <= 0; r_delay[p] <= 0;
            r_start[p] <= 0; r_act[p] <= 1'b0;
         end
      end else begin
         edge_no <= edge_no + 1;
         for (int p = 0; p < F; p++) begin
            if (activate[p]) begin
               if (m_busy(p, edge_no)) begin
                  m_err <= 1'b1;
               end else begin
                  r_init[p]  <= m_init[p];
                  r_step[p]  <= m_step[p];
                  r_iter[p]  <= m_iter[p];
                  r_delay[p] <= m_delay[p];
                  r_start[p] <= edge_no + 1;
                  r_act[p]   <= 1'b1;
               end
            end
         end
         if (instr_valid) begin
            if (instr[26:24] == 3'd1) begin
               m_init[instr[23:22]]  <= int'(instr[21:16]);
               m_step[instr[23:22]]  <= int'(instr[15:12]);
               m_iter[instr[23:22]]  <= int'(instr[11:6]);
               m_delay[instr[23:22]] <= int'(instr[5:0]);
            end else begin
               m_err <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int p = 0; p < F; p++) begin
         check($sformatf("model_valid%0d", p), 32'(addr_valid[p]), 32'(m_valid(p, edge_no)));
         check($sformatf("model_addr%0d", p), 32'(addr[p*A +: A]), 32'(m_addr(p, edge_no)));
         check($sformatf("model_busy%0d", p), 32'(busy[p]), 32'(m_busy(p, edge_no)));
      end
`ifdef RESOURCE_FSM_RECEIVER_ERR_EN
      check("model_err", 32'(err), 32'(m_err));
`endif
   end

   task automatic dsu(input int p, input int init, input int step, input int iter, input int dly);
      instr_valid = 1'b1;
      instr = {3'd1, 2'(p), 6'(init), 4'(step), 6'(iter), 6'(dly)};
      @(negedge clk);
      instr_valid = 1'b0;
      instr = '0;
   endtask

   task automatic act(input logic [F-1:0] mask);
      activate = mask;
      @(negedge clk);
      activate = '0;
   endtask

   function automatic int port_addr(input int p);
      return int'(addr[p*A +: A]);
   endfunction

   initial begin
      int exp_a[4];
      int exp_v[7];
      repeat (2) @(negedge clk);
      check("reset_valid", 32'(addr_valid), 0);
      check("reset_addr", 32'(addr), 0);
      check("reset_busy", 32'(busy), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Port 2: 5, 8, 11 back-to-back
      dsu(2, 5, 3, 2, 0);
      act(4'b0100);
      exp_a = '{5, 8, 11, 0};
      for (int k = 0; k < 3; k++) begin
         check("p2_valid", 32'(addr_valid[2]), 1);
         check("p2_addr", 32'(port_addr(2)), 32'(exp_a[k]));
         @(negedge clk);
      end
      check("p2_busy_fall", 32'(busy[2]), 0);

      // Port 0: wrap-around 62, 63, 0, 1
      dsu(0, 62, 1, 3, 0);
      act(4'b0001);
      exp_a = '{62, 63, 0, 1};
      for (int k = 0; k < 4; k++) begin
         check("p0_wrap_addr", 32'(port_addr(0)), 32'(exp_a[k]));
         @(negedge clk);
      end

      // Port 1: delay 2, second activate mid-run is ignored
      dsu(1, 0, 4, 2, 2);
      act(4'b0010);
      exp_v = '{1, 0, 0, 1, 0, 0, 1};
      for (int k = 0; k < 7; k++) begin
         check("p1_gap_valid", 32'(addr_valid[1]), 32'(exp_v[k]));
         if (exp_v[k] == 1) check("p1_gap_addr", 32'(port_addr(1)), 32'((k / 3) * 4));
         activate = (k == 1) ? 4'b0010 : 4'b0000;
         @(negedge clk);
      end
      check("p1_done", 32'(busy[1]), 0);
`ifdef RESOURCE_FSM_RECEIVER_ERR_EN
      check("err_busy_act", 32'(err), 1);
`endif

      // Port 3: DSU and activate on the same edge -> old (zero) config
      instr_valid = 1'b1;
      instr = {3'd1, 2'd3, 6'd9, 4'd1, 6'd0, 6'd0};
      activate = 4'b1000;
      @(negedge clk);
      instr_valid = 1'b0; instr = '0; activate = '0;
      check("p3_old_valid", 32'(addr_valid[3]), 1);
      check("p3_old_addr", 32'(port_addr(3)), 0);
      @(negedge clk);
      check("p3_old_done", 32'(busy[3]), 0);
      act(4'b1000);
      check("p3_new_addr", 32'(port_addr(3)), 9);
      @(negedge clk);

      // Simultaneous starts on ports 0 and 2
      act(4'b0101);
      check("multi_valid", 32'(addr_valid), 32'(4'b0101));
      check("multi_addr0", 32'(port_addr(0)), 62);
      check("multi_addr2", 32'(port_addr(2)), 5);
      repeat (5) @(negedge clk);

      // Asynchronous reset in the middle of a port 0 run
      dsu(0, 10, 1, 5, 0);
      act(4'b0001);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_valid", 32'(addr_valid[0]), 0);
      check("rst_async_busy", 32'(busy[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_quiet", 32'(addr_valid), 0);
      end

      // Unknown opcode is ignored by the generators
      instr_valid = 1'b1;
      instr = {3'd2, 2'd0, 6'd33, 4'd1, 6'd0, 6'd0};
      @(negedge clk);
      instr_valid = 1'b0; instr = '0;
      act(4'b0001);
      check("bad_op_ignored", 32'(port_addr(0)), 0);
`ifdef RESOURCE_FSM_RECEIVER_ERR_EN
      check("err_bad_op", 32'(err), 1);
`endif
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/resource_fsm_receiver.md
RESOURCE_FSM_RECEIVER -- requirements
Module: resource_fsm_receiver

Interface
REQ-001 SHALL have parameter FSM_PER_SLOT, default 4, meaning the number of independent address-generator ports per slot.
REQ-002 SHALL have parameter RESOURCE_INSTR_WIDTH, default 27, meaning the width of the slot instruction word.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6, meaning the width of a generated address.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port instr_valid, input, 1 bit: instr carries a valid slot instruction this cycle.
REQ-007 SHALL have port instr, input, RESOURCE_INSTR_WIDTH bits: {opcode[26:24], payload[23:0]}.
REQ-008 SHALL have port activate, input, FSM_PER_SLOT bits: one-cycle start pulse per port.
REQ-009 SHALL have port addr_valid, output, FSM_PER_SLOT bits: port p emits an address this cycle.
REQ-010 SHALL have port addr, output, FSM_PER_SLOT*ADDR_WIDTH bits: port p address at bits [p*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port busy, output, FSM_PER_SLOT bits: port p is not IDLE.

Function
REQ-012 SHALL decode opcode 1 (DSU) when instr_valid=1, with payload fields: port[23:22], init[21:16], step[15:12] (unsigned), iter[11:6], delay[5:0].
REQ-013 SHALL write DSU fields into the selected port's config register at the sampling edge; other opcodes SHALL be ignored.
REQ-014 SHALL give each port a state machine with the states IDLE, RUN and GAP.
REQ-015 SHALL, on activate[p]=1 in IDLE, copy config into working registers and enter RUN; the first addr_valid SHALL appear the cycle after the activate edge (latency 1).
REQ-016 SHALL, in RUN, assert addr_valid[p] for exactly one cycle per address, with addr = current address.
REQ-017 SHALL emit iter+1 addresses in total: init, init+step, ...; addition is modulo 2^ADDR_WIDTH (wrap-around, no saturation).
REQ-018 SHALL, after the (iter+1)-th address, return to IDLE.
REQ-019 SHALL, when not yet done and delay=0, stay in RUN and emit the next address on the next cycle.
REQ-020 SHALL, when not yet done and delay>0, enter GAP for exactly delay cycles with addr_valid=0, then return to RUN.
REQ-021 SHALL ignore activate[p] while port p is in RUN or GAP; the current run continues unchanged.
REQ-022 SHALL, when a DSU for port p arrives during a run, update only the config register; the active run keeps its working copy, and the next activation uses the new config.
REQ-023 SHALL, when a DSU and activate hit the same port on the same edge, start the run with the config held before that edge.
REQ-024 SHALL operate the ports fully independently; simultaneous activates on several ports all start.
REQ-025 SHALL drive addr for port p to 0 whenever addr_valid[p]=0.
REQ-026 SHALL set busy[p]=1 in RUN and GAP and 0 in IDLE; all outputs SHALL be registered.

Reset
REQ-027 SHALL, on rst_n=0, immediately force all ports to IDLE, clear all config and working registers to 0, and set addr_valid, addr and busy to 0.
REQ-028 SHALL, on reset asserted mid-run, abort the run with no further addresses after release.
REQ-029 SHALL run an activation of a never-configured port with all-zero config, emitting the single address 0.

Configuration
REQ-030 SHALL, with macro RESOURCE_FSM_RECEIVER_ERR_EN defined, add output err (1 bit, sticky, cleared only by reset), set the cycle after an activate on a busy port or a valid instruction with opcode other than 1.
REQ-031 SHALL, without RESOURCE_FSM_RECEIVER_ERR_EN, omit the err port and detection logic; functional behaviour is otherwise identical.

Verification
REQ-032 SHALL cover: DSU port2 init=5 step=3 iter=2 delay=0, activate[2] -> addr2 = 5, 8, 11 on three consecutive cycles starting one cycle later; busy[2] then falls.
REQ-033 SHALL cover: DSU port0 init=62 step=1 iter=3 delay=0 -> addr0 = 62, 63, 0, 1 (wrap-around).
REQ-034 SHALL cover: DSU port1 init=0 step=4 iter=2 delay=2 -> addr_valid[1] pulses at cycles t+1, t+4, t+7 with addresses 0, 4, 8.
REQ-035 SHALL cover: second activate[1] mid-run -> run unchanged; err=1 with ERR_EN and no err port without it.
REQ-036 SHALL cover: DSU port3 and activate[3] on the same edge (old config init=0, new init=9) -> run emits 0; the next activate emits 9.
REQ-037 SHALL cover: rst_n pulsed low during a port0 run -> addr_valid=0 and busy=0 immediately, and no addresses after release.
